// File: rtl/vga_glyph_fetch_pkg.sv
// Shared slot assignments, memory bases and state encodings for the
// text-mode glyph fetcher, so the arbiter and memory controller agree.
package vga_glyph_fetch_pkg;

  localparam int DW = 16;
  localparam int PW = 8;
  localparam int DEF_COLS = 80;

  localparam logic [DW-1:0] DEF_FB_BASE = 16'h8000;
  localparam logic [DW-1:0] DEF_GLYPH_BASE = 16'h0000;

  localparam logic [2:0] DEF_CHAR_SLOT = 3'd1;
  localparam logic [2:0] DEF_GLYPH_SLOT = 3'd5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_FETCH_CHAR = 3'd1;
  localparam state_t ST_FETCH_GLYPH = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/vga_glyph_fetch_shifter.sv
// Glyph row serialiser: 8-bit shift register, pixel counter and the
// cell-load / underrun decision.
module vga_glyph_fetch_shifter
  import vga_glyph_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic          pix_en,
  input  logic          active,
  input  logic          drain,
  input  logic          pat_valid,
  input  logic [PW-1:0] next_pat,
  output logic          load,
  output logic          pix_out,
  output logic          underrun
);

  logic [PW-1:0] shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          pix_q, pix_d;
  logic          und_q, und_d;
  logic          step;

  assign step = pix_en & active & ~line_start;
  assign load = step & (first_q | (cnt_q == 3'd7));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    pix_d   = pix_q;
    und_d   = und_q;
    if (line_start) begin
      shift_d = '0;
      cnt_d   = 3'd0;
      first_d = 1'b1;
      und_d   = 1'b0;
    end else if (step) begin
      first_d = 1'b0;
      if (load) begin
        // drain end and missed fetches both show a blank cell
        cnt_d   = 3'd0;
        shift_d = (drain || !pat_valid) ? '0 : next_pat;
        if (!pat_valid && !drain) und_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + 3'd1;
        shift_d = shift_q << 1;
      end
      pix_d = shift_d[PW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= 3'd0;
      first_q <= 1'b0;
      pix_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      pix_q   <= pix_d;
      und_q   <= und_d;
    end
  end

  assign pix_out  = pix_q;
  assign underrun = und_q;

endmodule

// File: rtl/vga_glyph_fetch.sv
// Display-side reader: fetches char code then glyph row in the VGA
// arbiter slots and feeds the serialiser, one cell ahead of the beam.
module vga_glyph_fetch
  import vga_glyph_fetch_pkg::*;
#(
  parameter int                   DATAWIDTH  = DW,
  parameter int                   COLS       = DEF_COLS,
  parameter logic [DATAWIDTH-1:0] FB_BASE    = DEF_FB_BASE,
  parameter logic [DATAWIDTH-1:0] GLYPH_BASE = DEF_GLYPH_BASE,
  parameter logic [2:0]           CHAR_SLOT  = DEF_CHAR_SLOT,
  parameter logic [2:0]           GLYPH_SLOT = DEF_GLYPH_SLOT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           acnt,
  input  logic [DATAWIDTH-1:0] dmem,
  input  logic                 line_start,
  input  logic [9:0]           vline,
  input  logic                 pix_en,
  output logic [DATAWIDTH-1:0] glyph_addr,
  output logic                 pix_out,
  output logic                 busy,
  output logic                 underrun
);

  localparam int CW = $clog2(COLS + 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [DATAWIDTH-1:0] base_q, base_d;
  logic [3:0]           grow_q, grow_d;
  logic [7:0]           code_q, code_d;
  logic [PW-1:0]        pat_q, pat_d;
  logic                 pat_valid_q, pat_valid_d;
  logic [DATAWIDTH-1:0] addr_q, addr_d;

  logic [DATAWIDTH-1:0] fb_addr;
  logic [DATAWIDTH-1:0] rom_addr;
  logic [CW-1:0]        col_nxt;
  logic                 load;
  logic                 drain;
  logic                 unused_dmem;

  assign unused_dmem = ^dmem[DATAWIDTH-1:8];

  assign busy    = (state_q != ST_IDLE);
  assign drain   = (state_q == ST_DRAIN);
  assign col_nxt = col_q + CW'(1);

  // line base is loaded once per line; the cell path is a single add
  assign fb_addr  = base_q + DATAWIDTH'(col_q);
  assign rom_addr = GLYPH_BASE + DATAWIDTH'({code_q, 4'b0000})
                  + DATAWIDTH'(grow_q);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    base_d      = base_q;
    grow_d      = grow_q;
    code_d      = code_q;
    pat_d       = pat_q;
    pat_valid_d = pat_valid_q;
    if (line_start) begin
      base_d      = FB_BASE
                  + DATAWIDTH'(int'(vline[9:4]) * COLS);
      grow_d      = vline[3:0];
      col_d       = '0;
      pat_valid_d = 1'b0;
      state_d     = ST_FETCH_CHAR;
    end else if (load && drain) begin
      state_d = ST_IDLE;
    end else if (load) begin
      pat_valid_d = 1'b0;
      col_d       = col_nxt;
      state_d     = (col_nxt == CW'(COLS)) ? ST_DRAIN
                                           : ST_FETCH_CHAR;
    end else begin
      unique case (state_q)
        ST_FETCH_CHAR: begin
          if (acnt == CHAR_SLOT) begin
            code_d  = dmem[7:0];
            state_d = ST_FETCH_GLYPH;
          end
        end
        ST_FETCH_GLYPH: begin
          if (acnt == GLYPH_SLOT) begin
            pat_d       = dmem[PW-1:0];
            pat_valid_d = 1'b1;
            state_d     = ST_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_d = addr_q;
    unique case (state_q)
      ST_FETCH_CHAR:  addr_d = fb_addr;
      ST_FETCH_GLYPH: addr_d = rom_addr;
      default:        addr_d = addr_q;
    endcase
  end

  assign glyph_addr = addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      base_q      <= '0;
      grow_q      <= 4'd0;
      code_q      <= 8'd0;
      pat_q       <= '0;
      pat_valid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      base_q      <= base_d;
      grow_q      <= grow_d;
      code_q      <= code_d;
      pat_q       <= pat_d;
      pat_valid_q <= pat_valid_d;
      addr_q      <= addr_d;
    end
  end

  vga_glyph_fetch_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .pix_en     (pix_en),
    .active     (busy),
    .drain      (drain),
    .pat_valid  (pat_valid_q),
    .next_pat   (pat_q),
    .load       (load),
    .pix_out    (pix_out),
    .underrun   (underrun)
  );

endmodule
